slr_credit_cross: RTL and testbench

- Flow-controlled companion to the plain SLR data crossing: carries a valid/ready stream across an SLR boundary and returns backpressure in the opposite direction.
- The forward path registers data+valid through a pipeline whose middle two stages are Laguna TX/RX registers.
- The reverse path returns one credit pulse per beat consumed downstream, through an identical pipeline.
- A receive-side FIFO absorbs all in-flight beats, so no combinational ready ever crosses the SLR.

---
 rtl/slr_credit_cross.sv | 217 +++++++++++++++++++++
 tb/tb_slr_credit_cross.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slr_credit_cross.sv
//------------------------------------------------------------------------------
// slr_credit_cross
//
// Credit-flow-controlled valid/ready stream crossing an SLR boundary.
// The forward path registers data+valid through LAT stages. The middle two
// stages are Laguna TX/RX registers. A receive-side first-word-fall-through
// FIFO of DEPTH entries absorbs every in-flight beat. Each FIFO pop sends one
// credit pulse back through an identical LAT-stage valid-only pipe. The
// sender-side counter starts at DEPTH. No combinational ready crosses the SLR.
//
// LAT = REGS_BEFORE + 2 + REGS_AFTER
//
// Ports:
//   clk        in   single clock for both paths
//   sreset     in   synchronous active-high reset
//   s_data     in   upstream data (WIDTH)
//   s_valid    in   upstream beat valid
//   s_ready    out  upstream ready, high when credits != 0 (low in reset)
//   m_data     out  downstream data, FIFO head (0 when empty)
//   m_valid    out  downstream valid, FIFO not empty
//   m_ready    in   downstream ready
//
// Optional (macro SLR_CREDIT_CROSS_STATS_EN):
//   level_hwm  out  FIFO occupancy high-water mark (clog2(DEPTH+1))
//   err_sticky out  set on FIFO write while full or credit overflow
//------------------------------------------------------------------------------
module slr_credit_cross #(
  parameter int REGS_BEFORE = 1,
  parameter int REGS_AFTER  = 1,
  parameter int WIDTH       = 16,
  parameter int DEPTH       = 16
) (
  input  logic                         clk,
  input  logic                         sreset,
  input  logic [WIDTH-1:0]             s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [WIDTH-1:0]             m_data,
  output logic                         m_valid,
  input  logic                         m_ready
`ifdef SLR_CREDIT_CROSS_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   level_hwm,
  output logic                         err_sticky
`endif
);

  localparam int LAT  = REGS_BEFORE + 2 + REGS_AFTER;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int AW   = $clog2(DEPTH);
  localparam int LAG0 = REGS_BEFORE;      // Laguna TX stage index
  localparam int LAG1 = REGS_BEFORE + 1;  // Laguna RX stage index

  logic          w_accept;
  logic          w_credit_ret;
  logic          w_pop;
  logic          w_wr;
  logic          w_full;
  logic          w_empty;

  //--------------------------------------------------------------------------
  // Sender-side credit counter
  //--------------------------------------------------------------------------
  logic [CW-1:0] r_credits;

  // Register-driven compare; sreset only gates it, no path from m_ready/s_valid.
  assign s_ready  = (r_credits != '0) && !sreset;
  assign w_accept = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_credits <= CW'(DEPTH);
    end else begin
      case ({w_accept, w_credit_ret})
        2'b10:   r_credits <= r_credits - CW'(1);
        2'b01:   r_credits <= r_credits + CW'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Forward pipe: element g is the input of stage g, element g+1 its output
  //--------------------------------------------------------------------------
  logic             w_fv [0:LAT];
  logic [WIDTH-1:0] w_fd [0:LAT];

  assign w_fv[0] = w_accept;
  assign w_fd[0] = s_data;

  for (genvar g = 0; g < LAT; g++) begin : g_fwd
    if (g == LAG0 || g == LAG1) begin : g_laguna
      (* USER_SLL_REG = "true", shreg_extract = "no" *) logic             r_v;
      (* USER_SLL_REG = "true", shreg_extract = "no" *) logic [WIDTH-1:0] r_d;

      always_ff @(posedge clk) begin
        if (sreset) r_v <= 1'b0;
        else        r_v <= w_fv[g];
      end

      // Laguna data flops carry no reset so they pack into the SLL sites.
      always_ff @(posedge clk) begin
        r_d <= w_fd[g];
      end

      assign w_fv[g+1] = r_v;
      assign w_fd[g+1] = r_d;
    end else begin : g_plain
      logic             r_v;
      logic [WIDTH-1:0] r_d;

      always_ff @(posedge clk) begin
        if (sreset) begin
          r_v <= 1'b0;
          r_d <= '0;
        end else begin
          r_v <= w_fv[g];
          r_d <= w_fd[g];
        end
      end

      assign w_fv[g+1] = r_v;
      assign w_fd[g+1] = r_d;
    end
  end

  //--------------------------------------------------------------------------
  // Receive FIFO (first-word-fall-through)
  //--------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign m_valid = !w_empty;
  assign m_data  = w_empty ? '0 : r_mem[r_rptr];
  assign w_pop   = m_valid && m_ready;
  // Credits make a full-FIFO write impossible; the guard protects contents anyway.
  assign w_wr    = w_fv[LAT] && !w_full;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_fd[LAT];
  end

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // Reverse credit pipe (valid only)
  //--------------------------------------------------------------------------
  logic w_cv [0:LAT];

  assign w_cv[0] = w_pop;

  for (genvar g = 0; g < LAT; g++) begin : g_rev
    if (g == LAG0 || g == LAG1) begin : g_laguna
      (* USER_SLL_REG = "true", shreg_extract = "no" *) logic r_v;

      always_ff @(posedge clk) begin
        if (sreset) r_v <= 1'b0;
        else        r_v <= w_cv[g];
      end

      assign w_cv[g+1] = r_v;
    end else begin : g_plain
      logic r_v;

      always_ff @(posedge clk) begin
        if (sreset) r_v <= 1'b0;
        else        r_v <= w_cv[g];
      end

      assign w_cv[g+1] = r_v;
    end
  end

  assign w_credit_ret = w_cv[LAT];

  //--------------------------------------------------------------------------
  // Optional statistics
  //--------------------------------------------------------------------------
`ifdef SLR_CREDIT_CROSS_STATS_EN
  logic [CW-1:0] r_hwm;
  logic          r_err;

  always_ff @(posedge clk) begin
    if (sreset) begin
      r_hwm <= '0;
      r_err <= 1'b0;
    end else begin
      r_hwm <= (r_count > r_hwm) ? r_count : r_hwm;
      if ((w_fv[LAT] && w_full) ||
          (w_credit_ret && !w_accept && (r_credits == CW'(DEPTH))))
        r_err <= 1'b1;
    end
  end

  assign level_hwm  = r_hwm;
  assign err_sticky = r_err;
`endif

endmodule

// File: tb/tb_slr_credit_cross.sv
//------------------------------------------------------------------------------
// tb_slr_credit_cross
//
// Directed bench for slr_credit_cross. Instance A uses the default
// configuration (LAT=4, DEPTH=16); instance B uses REGS_BEFORE=0,
// REGS_AFTER=0 (LAT=2). Inputs are driven 1ns after the rising edge and
// outputs are sampled on the falling edge. Cycle 0 of each test is the first
// cycle with sreset low.
//------------------------------------------------------------------------------
module tb_slr_credit_cross;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk;
  logic         sreset;

  logic [W-1:0] a_s_data, a_m_data;
  logic         a_s_valid, a_s_ready, a_m_valid, a_m_ready;
  logic [W-1:0] b_s_data, b_m_data;
  logic         b_s_valid, b_s_ready, b_m_valid, b_m_ready;
`ifdef SLR_CREDIT_CROSS_STATS_EN
  logic [4:0]   a_hwm, b_hwm;
  logic         a_err, b_err;
`endif

  slr_credit_cross #(
    .REGS_BEFORE(1), .REGS_AFTER(1), .WIDTH(W), .DEPTH(D)
  ) u_dut_a (
    .clk(clk), .sreset(sreset),
    .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
    .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready)
`ifdef SLR_CREDIT_CROSS_STATS_EN
    , .level_hwm(a_hwm), .err_sticky(a_err)
`endif
  );

  slr_credit_cross #(
    .REGS_BEFORE(0), .REGS_AFTER(0), .WIDTH(W), .DEPTH(D)
  ) u_dut_b (
    .clk(clk), .sreset(sreset),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready)
`ifdef SLR_CREDIT_CROSS_STATS_EN
    , .level_hwm(b_hwm), .err_sticky(b_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
  endtask

  // Leaves the caller at the start of cycle 0 with sreset low.
  task automatic do_reset();
    cyc_start();
    sreset = 1'b1;
    idle_inputs();
    sample();
    check("rst_sready_low_a", 32'(a_s_ready), 32'd0);
    cyc_start();
    sample();
    cyc_start();
    sreset = 1'b0;
  endtask

  int          a_nxt, a_exp, b_nxt, b_exp;
  int          first_out, last_out, lows, viol;
  logic [W-1:0] exp_d;
  logic [W-1:0] sb [$];

  // Global bound: a hang reports a failure and stops.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sreset = 1'b1;
    idle_inputs();

    //------------------------------------------------------------------
    // Single beat: A expects cycle 15, B (LAT=2) expects cycle 13
    //------------------------------------------------------------------
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) cyc_start();
      a_m_ready = 1'b1; b_m_ready = 1'b1;
      a_s_valid = (c == 10); b_s_valid = (c == 10);
      a_s_data  = (c == 10) ? 16'h1234 : 16'hDEAD;
      b_s_data  = (c == 10) ? 16'h1234 : 16'hDEAD;
      sample();
      if (c == 0) begin
        check("rst_mvalid_a", 32'(a_m_valid), 32'd0);
        check("rst_mdata_a",  32'(a_m_data),  32'd0);
        check("rst_mvalid_b", 32'(b_m_valid), 32'd0);
        check("rst_sready_b", 32'(b_s_ready), 32'd1);
      end
      check("single_sready_a", 32'(a_s_ready), 32'd1);
      check("single_mvalid_a", 32'(a_m_valid), 32'(c == 15));
      check("single_mvalid_b", 32'(b_m_valid), 32'(c == 13));
      if (c == 15) check("single_mdata_a", 32'(a_m_data), 32'h1234);
      if (c == 13) check("single_mdata_b", 32'(b_m_data), 32'h1234);
    end

    //------------------------------------------------------------------
    // Streaming 0..999 on A with m_ready held high
    //------------------------------------------------------------------
    do_reset();
    a_nxt = 0; a_exp = 0; first_out = -1; last_out = -1; lows = 0;
    for (int c = 0; c < 1100 && a_exp < 1000; c++) begin
      if (c > 0) cyc_start();
      a_s_valid = (a_nxt < 1000);
      a_s_data  = 16'(a_nxt);
      a_m_ready = 1'b1;
      sample();
      if (a_nxt > 0 && a_nxt < 1000 && !a_s_ready) lows++;
      if (a_s_valid && a_s_ready) a_nxt++;
      if (a_m_valid && a_m_ready) begin
        check("stream_data", 32'(a_m_data), 32'(a_exp));
        if (first_out < 0) first_out = c;
        last_out = c;
        a_exp++;
      end
    end
    check("stream_count",       32'(a_exp),               32'd1000);
    check("stream_first_cycle", 32'(first_out),           32'd5);
    check("stream_span",        32'(last_out - first_out), 32'd999);
    check("stream_sready_lows", 32'(lows),                32'd0);

    //------------------------------------------------------------------
    // Stall: 20 beats offered, m_ready raised in cycle 40 (A and B)
    //------------------------------------------------------------------
    do_reset();
    a_nxt = 0; a_exp = 0; b_nxt = 0; b_exp = 0;
    for (int c = 0; c < 400 && (a_exp < 20 || b_exp < 20); c++) begin
      if (c > 0) cyc_start();
      a_s_valid = (a_nxt < 20); a_s_data = 16'(a_nxt); a_m_ready = (c >= 40);
      b_s_valid = (b_nxt < 20); b_s_data = 16'(b_nxt); b_m_ready = (c >= 40);
      sample();
      if (c == 16) begin
        check("stall_accepted_a", 32'(a_nxt),     32'd16);
        check("stall_sready16_a", 32'(a_s_ready), 32'd0);
      end
      if (c == 44) check("stall_sready44_a", 32'(a_s_ready), 32'd0);
      if (c == 45) check("stall_sready45_a", 32'(a_s_ready), 32'd1);
      if (a_s_valid && a_s_ready) a_nxt++;
      if (b_s_valid && b_s_ready) b_nxt++;
      if (a_m_valid && a_m_ready) begin
        check("stall_data_a", 32'(a_m_data), 32'(a_exp));
        a_exp++;
      end
      if (b_m_valid && b_m_ready) begin
        check("stall_data_b", 32'(b_m_data), 32'(b_exp));
        b_exp++;
      end
    end
    check("stall_count_a", 32'(a_exp), 32'd20);
    check("stall_count_b", 32'(b_exp), 32'd20);
`ifdef SLR_CREDIT_CROSS_STATS_EN
    check("stall_hwm_a", 32'(a_hwm), 32'd16);
    check("stall_hwm_b", 32'(b_hwm), 32'd16);
    check("stall_err_b", 32'(b_err), 32'd0);
`endif

    //------------------------------------------------------------------
    // Reset mid-flight: 8 beats in A's FIFO, 3 in its pipe at cycle 12
    //------------------------------------------------------------------
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) cyc_start();
      a_m_ready = 1'b0;
      a_s_valid = (c <= 10);
      a_s_data  = 16'(16'h00A0 + c);
      sreset    = (c == 12);
      sample();
      if (c == 12) begin
        check("mid_sready_in_rst", 32'(a_s_ready), 32'd0);
        check("mid_mvalid_pre",    32'(a_m_valid), 32'd1);
      end
    end
    a_nxt = 0; a_exp = 0;
    for (int c = 13; c < 120; c++) begin
      cyc_start();
      sreset    = 1'b0;
      a_s_valid = (a_nxt < 16);
      a_s_data  = 16'(16'h0B00 + a_nxt);
      a_m_ready = (c >= 30);
      sample();
      if (c == 13) begin
        check("mid_mvalid_post", 32'(a_m_valid), 32'd0);
        check("mid_sready_post", 32'(a_s_ready), 32'd1);
      end
      if (c == 29) begin
        check("mid_credits", 32'(a_nxt),     32'd16);
        check("mid_sready29", 32'(a_s_ready), 32'd0);
      end
      if (a_s_valid && a_s_ready) a_nxt++;
      if (a_m_valid && a_m_ready) begin
        check("mid_data", 32'(a_m_data), 32'(16'h0B00 + a_exp));
        a_exp++;
      end
    end
    check("mid_count", 32'(a_exp), 32'd16);

    //------------------------------------------------------------------
    // Random 50% valid / ready on A with scoreboard
    //------------------------------------------------------------------
    do_reset();
    sb.delete();
    viol = 0;
    for (int c = 0; c < 10000; c++) begin
      if (c > 0) cyc_start();
      a_s_valid = 1'($urandom_range(0, 1));
      a_s_data  = 16'($urandom);
      a_m_ready = 1'($urandom_range(0, 1));
      sample();
      if (a_s_valid && a_s_ready) sb.push_back(a_s_data);
      if (a_m_valid && a_m_ready) begin
        if (sb.size() == 0) begin
          check("rand_spurious", 32'(a_m_valid), 32'd0);
        end else begin
          exp_d = sb.pop_front();
          check("rand_data", 32'(a_m_data), 32'(exp_d));
        end
      end
      if (sb.size() > D) viol++;
    end
    for (int c = 0; c < 200 && sb.size() != 0; c++) begin
      cyc_start();
      a_s_valid = 1'b0;
      a_m_ready = 1'b1;
      sample();
      if (a_m_valid && a_m_ready) begin
        exp_d = sb.pop_front();
        check("rand_drain_data", 32'(a_m_data), 32'(exp_d));
      end
    end
    check("rand_leftover",    32'(sb.size()), 32'd0);
    check("rand_outstanding", 32'(viol),      32'd0);
`ifdef SLR_CREDIT_CROSS_STATS_EN
    check("rand_err_a", 32'(a_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
